// File: rtl/trace_dump_ctrl_if.sv
// Bus bundle between the trace dump controller and its surroundings:
// command processor, capture unit, sample RAM and UART transmitter.
interface trace_dump_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
);
   // Command side
   logic              dump_req;
   logic              dump_abort;
   logic              capture_done;
   logic [ADDR_W-1:0] trace_end;
   // Capture unit RAM request
   logic [ADDR_W-1:0] cap_addr;
   logic              cap_en;
   logic              cap_we;
   // Muxed RAM port
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_en;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
   // UART side.
   // Handshake: tx_rdy is a level from the UART meaning "can accept a byte".
   // A byte is transferred in exactly the cycle where tx_start=1; tx_start is
   // only ever raised while tx_rdy=1, and tx_data carries that byte and stays
   // unchanged until the controller loads the next sample.
   logic              tx_rdy;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   // Status
   logic              busy;
   logic              dump_nak;
   logic              dump_done;
   logic              clr_capture_done;

   // Controller view
   modport master (
      input  dump_req, dump_abort, capture_done, trace_end,
      input  cap_addr, cap_en, cap_we,
      output ram_addr, ram_en, ram_we,
      input  ram_rdata,
      input  tx_rdy,
      output tx_start, tx_data,
      output busy, dump_nak, dump_done, clr_capture_done
   );

   // Environment view
   modport slave (
      output dump_req, dump_abort, capture_done, trace_end,
      output cap_addr, cap_en, cap_we,
      input  ram_addr, ram_en, ram_we,
      output ram_rdata,
      output tx_rdy,
      input  tx_start, tx_data,
      input  busy, dump_nak, dump_done, clr_capture_done
   );
endinterface

// File: rtl/trace_dump_ctrl.sv
// Trace dump controller: once a capture is complete, owns the sample RAM
// port and streams every sample, oldest first, to the UART transmitter,
// then re-arms the capture unit. The RAM port belongs to the capture unit
// whenever the controller is idle.
module trace_dump_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   trace_dump_ctrl_if.master bus,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD       = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_TX_START = 3'd3,
      S_TX_WAIT  = 3'd4,
      S_FIN      = 3'd5
   } state_t;

   // Last value of the read-wait counter before the RAM data is valid.
   localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT - 1);
   localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [ADDR_W:0]     cnt;
   logic [1:0]          wait_cnt;
   logic                ign_rdy;
   logic [DATA_W-1:0]   tx_data_q;
   logic                nak_q;

   logic                ld_ptr;
   logic                adv_ptr;
   logic                cap_byte;
   logic                nak_nxt;
   logic                rd_en;
   logic                tx_start_c;
   logic                done_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and strobe decode; abort overrides everything outside IDLE
   always_comb begin
      state_nxt  = state;
      ld_ptr     = 1'b0;
      adv_ptr    = 1'b0;
      cap_byte   = 1'b0;
      nak_nxt    = 1'b0;
      rd_en      = 1'b0;
      tx_start_c = 1'b0;
      done_c     = 1'b0;
      case (state)
         S_IDLE: begin
            // An abort in the same cycle drops the request without a nak.
            if (bus.dump_req && !bus.dump_abort) begin
               if (bus.capture_done) begin
                  ld_ptr    = 1'b1;
                  state_nxt = S_RD;
               end else begin
                  nak_nxt = 1'b1;
               end
            end
         end
         S_RD: begin
            rd_en     = 1'b1;
            state_nxt = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               cap_byte  = 1'b1;
               state_nxt = S_TX_START;
            end
         end
         S_TX_START: begin
            if (bus.tx_rdy) begin
               tx_start_c = 1'b1;
               adv_ptr    = 1'b1;
               state_nxt  = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            // The UART may still show ready in the cycle right after the
            // strobe, before it has registered the new byte.
            if (!ign_rdy && bus.tx_rdy) begin
               state_nxt = (cnt < DEPTH_C) ? S_RD : S_FIN;
            end
         end
         S_FIN: begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (state != S_IDLE && bus.dump_abort) begin
         state_nxt  = S_IDLE;
         adv_ptr    = 1'b0;
         cap_byte   = 1'b0;
         tx_start_c = 1'b0;
         done_c     = 1'b0;
      end
   end

   // Read pointer, byte count, read-latency counter, output byte and nak
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         cnt       <= '0;
         wait_cnt  <= '0;
         ign_rdy   <= 1'b0;
         tx_data_q <= '0;
         nak_q     <= 1'b0;
      end else begin
         nak_q   <= nak_nxt;
         ign_rdy <= adv_ptr;
         if (ld_ptr) begin
            // Oldest sample sits just after the newest; wraps mod DEPTH.
            rd_ptr <= bus.trace_end + ADDR_W'(1);
            cnt    <= '0;
         end else if (adv_ptr) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            cnt    <= cnt + (ADDR_W + 1)'(1);
         end
         if (state == S_RD) begin
            wait_cnt <= '0;
         end else if (state == S_RD_WAIT) begin
            wait_cnt <= wait_cnt + 2'd1;
         end
         if (cap_byte) begin
            tx_data_q <= bus.ram_rdata;
         end
      end
   end

   // RAM port arbitration: capture unit in IDLE, read-only dump otherwise
   always_comb begin
      if (state == S_IDLE) begin
         bus.ram_addr = bus.cap_addr;
         bus.ram_en   = bus.cap_en;
         bus.ram_we   = bus.cap_we;
      end else begin
         bus.ram_addr = rd_ptr;
         bus.ram_en   = rd_en;
         bus.ram_we   = 1'b0;
      end
   end

   assign bus.tx_start         = tx_start_c;
   assign bus.tx_data          = tx_data_q;
   assign bus.busy             = (state != S_IDLE);
   assign bus.dump_nak         = nak_q;
   assign bus.dump_done        = done_c;
   assign bus.clr_capture_done = done_c;
   assign dbg_state            = state;

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// Bench for trace_dump_ctrl: a behavioural sample RAM with configurable read
// latency, a UART-side byte collector, and an expected byte stream computed
// directly from trace_end and the RAM contents.
module tb_trace_dump_ctrl;
   localparam int AW    = 9;
   localparam int DW    = 8;
   localparam int DEPTH = 512;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          req_lat  = 1'b0;
   logic          rdy_mode = 1'b0;
   logic          rdy_val  = 1'b1;
   logic          rdy_rand = 1'b1;
   logic [2:0]    dbg1, dbg2, dbg3;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] exp_q[$];
   logic [AW:0]   s1_0, s2_0, s2_1, s3_0, s3_1, s3_2;
   int checks = 0, passed = 0;
   int done_cnt = 0, clr_cnt = 0, nak_cnt = 0, pair_err = 0, we_err = 0, strobe_err = 0;

   always #5 clk = ~clk;

   trace_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   trace_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
   trace_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

   trace_dump_ctrl #(.RD_LAT(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1));
   trace_dump_ctrl #(.RD_LAT(2)) u_lat2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state(dbg2));
   trace_dump_ctrl #(.RD_LAT(3)) u_lat3 (.clk(clk), .rst_n(rst_n), .bus(bus3), .dbg_state(dbg3));

   // UART ready: fixed level or a fresh random level every cycle
   always @(posedge clk) rdy_rand <= 1'($urandom_range(0, 1));
   assign bus1.tx_rdy = rdy_mode ? rdy_rand : rdy_val;

   // The latency instances share everything with bus1 except the request
   assign bus2.dump_req = req_lat;       assign bus3.dump_req = req_lat;
   assign bus2.dump_abort = bus1.dump_abort;     assign bus3.dump_abort = bus1.dump_abort;
   assign bus2.capture_done = bus1.capture_done; assign bus3.capture_done = bus1.capture_done;
   assign bus2.trace_end = bus1.trace_end;       assign bus3.trace_end = bus1.trace_end;
   assign bus2.cap_addr = bus1.cap_addr;         assign bus3.cap_addr = bus1.cap_addr;
   assign bus2.cap_en = bus1.cap_en;             assign bus3.cap_en = bus1.cap_en;
   assign bus2.cap_we = bus1.cap_we;             assign bus3.cap_we = bus1.cap_we;
   assign bus2.tx_rdy = bus1.tx_rdy;             assign bus3.tx_rdy = bus1.tx_rdy;

   // Sample RAM: data for an enabled read appears RD_LAT cycles later
   function automatic logic [DW-1:0] rd_mem(input logic [AW:0] s);
      if (s[AW]) return mem[s[AW-1:0]];
      return 8'hxx;
   endfunction

   always @(posedge clk) begin
      s1_0 <= {bus1.ram_en, bus1.ram_addr};
      s2_0 <= {bus2.ram_en, bus2.ram_addr};
      s2_1 <= s2_0;
      s3_0 <= {bus3.ram_en, bus3.ram_addr};
      s3_1 <= s3_0;
      s3_2 <= s3_1;
   end
   assign bus1.ram_rdata = rd_mem(s1_0);
   assign bus2.ram_rdata = rd_mem(s2_1);
   assign bus3.ram_rdata = rd_mem(s3_2);

   // Collector / event counters, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus1.tx_start) begin
            got_q.push_back(bus1.tx_data);
            if (bus1.tx_rdy !== 1'b1) strobe_err++;
         end
         if (bus1.dump_done) done_cnt++;
         if (bus1.clr_capture_done) clr_cnt++;
         if (bus1.dump_done !== bus1.clr_capture_done) pair_err++;
         if (bus1.dump_nak) nak_cnt++;
         if ((bus1.busy && bus1.ram_we !== 1'b0) || (bus2.busy && bus2.ram_we !== 1'b0) ||
             (bus3.busy && bus3.ram_we !== 1'b0)) we_err++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected dump: DEPTH bytes starting just after the newest sample
   task automatic build_exp(input logic [AW-1:0] te);
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[(int'(te) + 1 + i) % DEPTH]);
   endtask

   task automatic start_dump(input logic [AW-1:0] te);
      bus1.trace_end    = te;
      bus1.capture_done = 1'b1;
      bus1.dump_req     = 1'b1;
      tick();
      bus1.dump_req = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (got_q.size() >= n) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt != d0) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      logic [AW-1:0] a;
      rst_n = 1'b0;
      bus1.dump_req = 0; bus1.dump_abort = 0; bus1.capture_done = 0; bus1.trace_end = '0;
      bus1.cap_addr = '0; bus1.cap_en = 0; bus1.cap_we = 0;
      repeat (3) tick();
      checks++; if (bus1.busy === 1'b0) passed++; else $display("FAIL reset_busy: got %b required 0", bus1.busy);
      checks++; if (bus1.tx_start === 1'b0) passed++; else $display("FAIL reset_tx_start: got %b required 0", bus1.tx_start);
      checks++; if (bus1.tx_data === 8'h00) passed++; else $display("FAIL reset_tx_data: got %h required 00", bus1.tx_data);
      checks++; if ({bus1.dump_nak, bus1.dump_done, bus1.clr_capture_done} === 3'b000) passed++;
      else $display("FAIL reset_pulses: got %b required 000", {bus1.dump_nak, bus1.dump_done, bus1.clr_capture_done});
      rst_n = 1'b1;
      tick();
      a = AW'($urandom_range(0, DEPTH - 1));
      bus1.cap_addr = a; bus1.cap_en = 1; bus1.cap_we = 1;
      #1;
      checks++; if ({bus1.ram_addr, bus1.ram_en, bus1.ram_we} === {a, 2'b11}) passed++;
      else $display("FAIL idle_mux: got %h/%b/%b required %h/1/1", bus1.ram_addr, bus1.ram_en, bus1.ram_we, a);
      bus1.cap_en = 0; bus1.cap_we = 0;
      tick();
   endtask

   task automatic test_nak();
      int n0;
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, DEPTH - 1));
      bus1.capture_done = 0; bus1.cap_addr = a; bus1.cap_en = 1;
      n0 = nak_cnt;
      bus1.dump_req = 1; tick(); bus1.dump_req = 0;
      checks++; if (bus1.dump_nak === 1'b1) passed++; else $display("FAIL nak_pulse: got %b required 1", bus1.dump_nak);
      checks++; if (bus1.busy === 1'b0) passed++; else $display("FAIL nak_busy: got %b required 0", bus1.busy);
      checks++; if (bus1.ram_addr === a && bus1.ram_en === 1'b1) passed++;
      else $display("FAIL nak_mux: got %h/%b required %h/1", bus1.ram_addr, bus1.ram_en, a);
      tick();
      checks++; if (nak_cnt - n0 == 1 && bus1.dump_nak === 1'b0) passed++;
      else $display("FAIL nak_width: got %0d pulse cycles required 1", nak_cnt - n0);
      bus1.cap_en = 0;
   endtask

   task automatic test_req_abort();
      int n0;
      n0 = nak_cnt;
      bus1.capture_done = 1; bus1.dump_req = 1; bus1.dump_abort = 1;
      tick();
      bus1.dump_req = 0; bus1.dump_abort = 0;
      tick();
      checks++; if (bus1.busy === 1'b0 && nak_cnt == n0) passed++;
      else $display("FAIL req_abort: got busy %b nak %0d required busy 0 nak 0", bus1.busy, nak_cnt - n0);
   endtask

   task automatic test_dump(input string name, input logic [AW-1:0] te);
      bit ok;
      int d0, c0, p0, w0, s0, n0, bad;
      got_q.delete(); build_exp(te);
      d0 = done_cnt; c0 = clr_cnt; p0 = pair_err; w0 = we_err; s0 = strobe_err;
      // Capture unit keeps requesting writes; the dump must ignore it.
      bus1.cap_en = 1; bus1.cap_we = 1; bus1.cap_addr = AW'($urandom_range(0, DEPTH - 1));
      start_dump(te);
      wait_bytes(50, 4000, ok);
      n0 = nak_cnt;
      bus1.dump_req = 1; tick(); bus1.dump_req = 0; tick(); tick();
      checks++; if (ok && nak_cnt == n0) passed++;
      else $display("FAIL %s busy_req: got nak %0d reached %0d required nak 0 reached 1", name, nak_cnt - n0, ok);
      wait_done(d0, 8000, ok);
      bus1.cap_en = 0; bus1.cap_we = 0;
      checks++; if (ok) passed++; else $display("FAIL %s done_timeout: got no dump_done required one", name);
      checks++; if (got_q.size() == DEPTH) passed++;
      else $display("FAIL %s byte_count: got %0d required %0d", name, got_q.size(), DEPTH);
      bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin bad = i; break; end
      checks++; if (bad < 0) passed++;
      else $display("FAIL %s data[%0d]: got %h required %h", name, bad, got_q[bad], exp_q[bad]);
      if (got_q.size() > 0) begin
         checks++; if (got_q[$] === mem[te]) passed++;
         else $display("FAIL %s last_byte: got %h required %h", name, got_q[$], mem[te]);
      end
      checks++; if (done_cnt - d0 == 1 && clr_cnt - c0 == 1 && pair_err == p0) passed++;
      else $display("FAIL %s done_clr: got done %0d clr %0d split %0d required 1 1 0", name,
                    done_cnt - d0, clr_cnt - c0, pair_err - p0);
      checks++; if (we_err == w0 && strobe_err == s0) passed++;
      else $display("FAIL %s we_strobe: got ram_we %0d strobe_no_rdy %0d required 0 0", name, we_err - w0, strobe_err - s0);
      checks++; if (bus1.busy === 1'b0) passed++; else $display("FAIL %s idle_after: got busy %b required 0", name, bus1.busy);
   endtask

   task automatic test_stall(input logic [AW-1:0] te);
      bit ok;
      int n0, d0, bad;
      logic [DW-1:0] hold;
      got_q.delete(); build_exp(te); d0 = done_cnt;
      start_dump(te);
      for (int k = 0; k < 2; k++) begin
         wait_bytes(2 + k, 400, ok);
         checks++; if (ok) passed++; else $display("FAIL stall%0d_reach: got %0d bytes required %0d", k, got_q.size(), 2 + k);
         repeat (3 * k) tick();
         rdy_val = 1'b0; n0 = got_q.size();
         repeat (5) tick();
         hold = bus1.tx_data;
         repeat (15) tick();
         checks++; if (got_q.size() == n0) passed++;
         else $display("FAIL stall%0d_held: got %0d strobes required 0", k, got_q.size() - n0);
         checks++; if (bus1.tx_data === hold) passed++;
         else $display("FAIL stall%0d_data: got %h required %h", k, bus1.tx_data, hold);
         rdy_val = 1'b1;
      end
      wait_done(d0, 8000, ok);
      bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin bad = i; break; end
      checks++; if (ok && got_q.size() == DEPTH && bad < 0) passed++;
      else $display("FAIL stall_stream: got %0d bytes first bad %0d done %0d required %0d bytes none bad", got_q.size(), bad, ok, DEPTH);
   endtask

   task automatic test_abort();
      bit ok;
      int n0, d0, c0;
      logic [AW-1:0] te;
      te = AW'($urandom_range(0, DEPTH - 1));
      for (int r = 0; r < 3; r++) begin
         got_q.delete(); d0 = done_cnt; c0 = clr_cnt;
         start_dump(te);
         wait_bytes(100, 1000, ok);
         repeat ($urandom_range(0, 4)) tick();
         n0 = got_q.size();
         bus1.dump_abort = 1; tick(); bus1.dump_abort = 0;
         checks++; if (ok && bus1.busy === 1'b0) passed++;
         else $display("FAIL abort%0d_idle: got busy %b reached %0d required busy 0", r, bus1.busy, ok);
         checks++; if (got_q.size() == n0) passed++;
         else $display("FAIL abort%0d_strobe: got %0d strobes in abort cycle required 0", r, got_q.size() - n0);
         repeat (10) tick();
         checks++; if (got_q.size() == n0 && done_cnt == d0 && clr_cnt == c0) passed++;
         else $display("FAIL abort%0d_quiet: got strobes %0d done %0d clr %0d required 0 0 0", r,
                       got_q.size() - n0, done_cnt - d0, clr_cnt - c0);
      end
      test_dump("abort_restart", te);
   endtask

   task automatic test_async_reset();
      bit ok;
      logic [AW-1:0] a;
      start_dump(AW'($urandom_range(0, DEPTH - 1)));
      wait_bytes(5, 400, ok);
      #2;
      a = AW'($urandom_range(0, DEPTH - 1));
      bus1.cap_addr = a; bus1.cap_en = 1; bus1.cap_we = 0;
      rst_n = 1'b0;
      #1;
      checks++; if (ok && bus1.busy === 1'b0 && bus1.tx_start === 1'b0) passed++;
      else $display("FAIL arst_idle: got busy %b tx_start %b required 0 0", bus1.busy, bus1.tx_start);
      checks++; if (bus1.ram_addr === a && bus1.ram_en === 1'b1) passed++;
      else $display("FAIL arst_mux: got %h/%b required %h/1", bus1.ram_addr, bus1.ram_en, a);
      @(posedge clk); #1;
      rst_n = 1'b1; bus1.cap_en = 0;
      tick();
   endtask

   task automatic test_latency();
      int l1, l2, l3, w0;
      logic [DW-1:0] d1, d2, d3, e;
      logic [AW-1:0] te;
      te = AW'($urandom_range(0, DEPTH - 1));
      e = mem[(int'(te) + 1) % DEPTH];
      l1 = -1; l2 = -1; l3 = -1; d1 = '0; d2 = '0; d3 = '0; w0 = we_err;
      rdy_val = 1'b1; bus1.trace_end = te; bus1.capture_done = 1;
      bus1.dump_req = 1; req_lat = 1; tick(); bus1.dump_req = 0; req_lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (bus1.tx_start && l1 < 0) begin l1 = n; d1 = bus1.tx_data; end
         if (bus2.tx_start && l2 < 0) begin l2 = n; d2 = bus2.tx_data; end
         if (bus3.tx_start && l3 < 0) begin l3 = n; d3 = bus3.tx_data; end
         tick();
      end
      checks++; if (l1 == 3) passed++; else $display("FAIL lat1: got %0d cycles required 3", l1);
      checks++; if (l2 == 4) passed++; else $display("FAIL lat2: got %0d cycles required 4", l2);
      checks++; if (l3 == 5) passed++; else $display("FAIL lat3: got %0d cycles required 5", l3);
      checks++; if (d1 === e && d2 === e && d3 === e) passed++;
      else $display("FAIL lat_first_byte: got %h/%h/%h required %h", d1, d2, d3, e);
      bus1.dump_abort = 1; tick(); bus1.dump_abort = 0;
      checks++; if ({bus1.busy, bus2.busy, bus3.busy} === 3'b000 && we_err == w0) passed++;
      else $display("FAIL lat_end: got busy %b ram_we %0d required 000 0", {bus1.busy, bus2.busy, bus3.busy}, we_err - w0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 255));
      test_reset();
      test_nak();
      test_req_abort();
      test_dump("full_1ff", 9'h1FF);
      test_dump("wrap_0a0", 9'h0A0);
      test_stall(AW'($urandom_range(0, DEPTH - 1)));
      test_abort();
      rdy_mode = 1'b1;
      test_dump("rand_rdy", AW'($urandom_range(0, DEPTH - 1)));
      rdy_mode = 1'b0;
      test_async_reset();
      test_dump("post_reset", AW'($urandom_range(0, DEPTH - 1)));
      test_latency();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
